spi_slave_param: RTL and testbench

Parametrised SPI slave front-end for the single-port RAM subsystem. It deserialises master frames of {2-bit command, payload} into a parallel word for the RAM controller and serialises RAM read data back on MISO through a tx_valid/tx_ready handshake. It adds the following features:
- configurable address and data widths
- MSB/LSB-first ordering
- back-to-back frames within one SS_n assertion
- frame and sequence error reporting

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_shift_reg.sv | 38 +++
 rtl/spi_slave_param.sv | 147 ++++++++++++++
 tb/tb_spi_slave_param.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front-end: frame commands and the
// controller state encoding.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEL       = 3'd1,
    RECV      = 3'd2,
    READ_WAIT = 3'd3,
    SEND      = 3'd4
  } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Bidirectional-order shift register. data_o and shift_out_o show the contents
// as they will be after this edge, so the caller can capture them on the same edge.
module spi_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             shift_in_i,
  output logic [WIDTH-1:0] data_o,
  output logic             shift_out_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // NOTE: data_d gets a default before any branch, so always_comb never infers a latch.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      if (LSB_FIRST) data_d = {shift_in_i, data_q[WIDTH-1:1]};
      else           data_d = {data_q[WIDTH-2:0], shift_in_i};
    end
  end

  // NOTE: no reset on this datapath: every bit is loaded or shifted in before it is read.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data_o      = data_d;
  assign shift_out_o = LSB_FIRST ? data_d[0] : data_d[WIDTH-1];

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises {cmd, payload} frames for the RAM controller
// and serialises RAM read data back on MISO after a read-address/read-data pair.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int PAY_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W,
  localparam int W        = PAY_W + 2
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              MISO,
  output logic [W-1:0]      rx_data,
  output logic              rx_valid,
  output logic              frame_err
);

  localparam int             CNT_W    = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] DATA_MAX = CNT_W'(DATA_W - 1);

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             addr_seen_q;
  logic [W-1:0]     rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             miso_q;

  logic [W-1:0]      rx_frame_d;
  logic [1:0]        rx_cmd_d;
  logic              tx_bit_d;
  logic              rx_serial_unused;
  logic [DATA_W-1:0] tx_par_unused;

  spi_shift_reg #(
    .WIDTH     (W),
    .LSB_FIRST (LSB_FIRST)
  ) u_rx_shift (
    .clk         (sclk),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (state_q == RECV),
    .shift_in_i  (MOSI),
    .data_o      (rx_frame_d),
    .shift_out_o (rx_serial_unused)
  );

  spi_shift_reg #(
    .WIDTH     (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_tx_shift (
    .clk         (sclk),
    .load_i      ((state_q == READ_WAIT) && tx_valid),
    .load_data_i (tx_data),
    .shift_i     (state_q == SEND),
    .shift_in_i  (1'b0),
    .data_o      (tx_par_unused),
    .shift_out_o (tx_bit_d)
  );

  assign rx_cmd_d = rx_frame_d[W-1 -: 2];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= CNT_MAX;
      addr_seen_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (SS_n) begin
        // Deselect mid-frame is an error; deselect during a read is a silent abort.
        if (state_q == RECV && bit_cnt_q != CNT_MAX) frame_err_q <= 1'b1;
        state_q   <= IDLE;
        bit_cnt_q <= CNT_MAX;
        miso_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= SEL;
          SEL: begin
            state_q   <= RECV;
            bit_cnt_q <= CNT_MAX;
          end
          RECV: begin
            if (bit_cnt_q == '0) begin
              rx_data_q  <= rx_frame_d;
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= CNT_MAX;
              case (rx_cmd_d)
                CMD_RD_ADDR: addr_seen_q <= 1'b1;
                CMD_RD_DATA: begin
                  if (addr_seen_q) begin
                    addr_seen_q <= 1'b0;
                    state_q     <= READ_WAIT;
                  end else begin
                    frame_err_q <= 1'b1;
                  end
                end
                default: ;
              endcase
            end else begin
              bit_cnt_q <= bit_cnt_q - 1'b1;
            end
          end
          READ_WAIT: begin
            if (tx_valid) begin
              miso_q    <= tx_bit_d;
              bit_cnt_q <= DATA_MAX;
              state_q   <= SEND;
            end
          end
          SEND: begin
            if (bit_cnt_q == '0) begin
              miso_q    <= 1'b0;
              bit_cnt_q <= CNT_MAX;
              state_q   <= RECV;
            end else begin
              miso_q    <= tx_bit_d;
              bit_cnt_q <= bit_cnt_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready  = (state_q == READ_WAIT);
  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: an MSB-first and an LSB-first instance
// share one stimulus stream; each scenario checks only the instance it targets.
module tb_spi_slave_param;

  localparam int W = 10;

  logic       sclk = 1'b0;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic         tx_ready_m, miso_m, rx_valid_m, frame_err_m;
  logic [W-1:0] rx_data_m;
  logic         tx_ready_l, miso_l, rx_valid_l, frame_err_l;
  logic [W-1:0] rx_data_l;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 sclk = ~sclk;

  spi_slave_param #(.ADDR_W(8), .DATA_W(8), .LSB_FIRST(1'b0)) dut_m (
    .sclk(sclk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_m),
    .MISO(miso_m), .rx_data(rx_data_m), .rx_valid(rx_valid_m), .frame_err(frame_err_m)
  );

  spi_slave_param #(.ADDR_W(8), .DATA_W(8), .LSB_FIRST(1'b1)) dut_l (
    .sclk(sclk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_l),
    .MISO(miso_l), .rx_data(rx_data_l), .rx_valid(rx_valid_l), .frame_err(frame_err_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; ss_n = 1'b1; tx_valid = 1'b0; mosi = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // From IDLE with SS_n falling: IDLE->SEL edge, then SEL->RECV edge.
  task automatic select();
    ss_n = 1'b0;
    mosi = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_frame(input logic [W-1:0] f, input bit lsb, output int vcyc);
    vcyc = -1;
    for (int i = 0; i < W; i++) begin
      mosi = lsb ? f[i] : f[W-1-i];
      tick();
      if (vcyc < 0 && (lsb ? rx_valid_l : rx_valid_m)) vcyc = cyc;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         c0, vc, v1, v2;
    logic [7:0] exp_c3;
    logic [7:0] exp_b4;
    exp_c3  = 8'hC3;
    exp_b4  = 8'hB4;
    tx_data = 8'h00;
    do_reset();

    check("rst_rx_data",   rx_data_m,   0);
    check("rst_rx_valid",  rx_valid_m,  0);
    check("rst_miso",      miso_m,      0);
    check("rst_frame_err", frame_err_m, 0);
    check("rst_tx_ready",  tx_ready_m,  0);

    // Write-address frame, MSB-first.
    select();
    c0 = cyc;
    send_frame(10'h0A5, 1'b0, vc);
    check("wa_valid_cycle", vc, c0 + W);
    check("wa_rx_data",     rx_data_m, 10'h0A5);
    check("wa_frame_err",   frame_err_m, 0);
    ss_n = 1'b1;
    tick();
    check("wa_valid_one_cycle", rx_valid_m, 0);
    check("wa_close_no_err",    frame_err_m, 0);

    // Read sequence: read address, read data, then serialise 0xC3.
    select();
    send_frame(10'h203, 1'b0, vc);
    check("ra_rx_data",  rx_data_m,  10'h203);
    check("ra_rx_valid", rx_valid_m, 1);
    send_frame(10'h300, 1'b0, vc);
    check("rd_rx_valid",  rx_valid_m,  1);
    check("rd_frame_err", frame_err_m, 0);
    check("rd_tx_ready",  tx_ready_m,  1);
    tick();
    tick();
    check("rd_wait_ready", tx_ready_m, 1);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      check($sformatf("rd_miso_bit%0d", k), miso_m, exp_c3[7-k]);
    end
    tick();
    check("rd_miso_after", miso_m,     0);
    check("rd_ready_drop", tx_ready_m, 0);
    send_frame(10'h15A, 1'b0, vc);
    check("rd_then_recv", rx_data_m, 10'h15A);
    ss_n = 1'b1;
    tick();

    // Read data without a preceding read address.
    do_reset();
    select();
    send_frame(10'h300, 1'b0, vc);
    check("nra_rx_valid",  rx_valid_m,  1);
    check("nra_frame_err", frame_err_m, 1);
    check("nra_rx_data",   rx_data_m,   10'h300);
    check("nra_tx_ready",  tx_ready_m,  0);
    ss_n = 1'b1;
    tick();
    check("nra_err_one_cycle", frame_err_m, 0);

    // Abort after four data bits.
    select();
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      tick();
    end
    ss_n = 1'b1;
    tick();
    check("ab_frame_err", frame_err_m, 1);
    check("ab_rx_valid",  rx_valid_m,  0);
    check("ab_rx_data",   rx_data_m,   10'h300);
    tick();
    check("ab_err_one_cycle", frame_err_m, 0);
    select();
    c0 = cyc;
    send_frame(10'h1C3, 1'b0, vc);
    check("ab_restart_cycle", vc, c0 + W);
    check("ab_restart_data",  rx_data_m, 10'h1C3);

    // Reset while bit 3 of 0xB4 is on MISO.
    send_frame(10'h2FF, 1'b0, vc);
    send_frame(10'h300, 1'b0, vc);
    check("rs_tx_ready", tx_ready_m, 1);
    tx_data  = 8'hB4;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    tick();
    check("rs_bit3", miso_m, exp_b4[4]);
    rst      = 1'b1;
    tx_valid = 1'b1;
    tick();
    rst      = 1'b0;
    tx_valid = 1'b0;
    check("rs_miso",      miso_m,      0);
    check("rs_tx_ready0", tx_ready_m,  0);
    check("rs_rx_data",   rx_data_m,   0);
    check("rs_rx_valid",  rx_valid_m,  0);
    check("rs_frame_err", frame_err_m, 0);
    select();
    send_frame(10'h300, 1'b0, vc);
    check("rs_addr_seen_clr", frame_err_m, 1);
    check("rs_no_read",       tx_ready_m,  0);
    ss_n = 1'b1;
    tick();

    // Back-to-back LSB-first write frames.
    do_reset();
    select();
    c0 = cyc;
    send_frame(10'h155, 1'b1, v1);
    check("lsb_first_cycle", v1, c0 + W);
    check("lsb_first_data",  rx_data_l, 10'h155);
    send_frame(10'h0AA, 1'b1, v2);
    check("lsb_gap",         v2 - v1, W);
    check("lsb_second_data", rx_data_l, 10'h0AA);
    check("lsb_frame_err",   frame_err_l, 0);
    ss_n = 1'b1;
    tick();
    check("lsb_valid_low", rx_valid_l, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
